nested_loop_counter: RTL

Parametrised multi-dimensional loop counter that sequences the feature-map scan of the streaming convolution datapath. It walks up to NUM_DIMS nested indices (dim 0 innermost, e.g. column, row, channel), each wrapping at its own runtime target. It provides per-dimension wrap flags, a last-element flag, and a start/busy/done handshake. A latched continuous mode lets it re-run frames back-to-back without software intervention.

---
 rtl/nested_loop_counter.sv | 96 +++++++++
 1 files changed

// File: rtl/nested_loop_counter.sv
// Multi-dimensional nested loop counter for feature-map scans. Dim 0 is innermost.
// Each dim wraps at its own latched runtime target; targets and continuous mode are latched on start.
module nested_loop_counter #(
  parameter int unsigned NUM_DIMS = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_start,
  input  logic                      i_clear,
  input  logic                      i_step,
  input  logic                      i_cont,
  input  logic [NUM_DIMS*CNT_W-1:0] i_target,
  output logic [NUM_DIMS*CNT_W-1:0] o_count,
  output logic [NUM_DIMS-1:0]       o_wrap,
  output logic                      o_last,
  output logic                      o_busy,
  output logic                      o_done
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]                r_state;
  logic [NUM_DIMS*CNT_W-1:0] r_target;
  logic [NUM_DIMS*CNT_W-1:0] r_count;
  logic                      r_cont;
  logic                      r_done;

  logic [NUM_DIMS*CNT_W-1:0] w_max;
  logic [NUM_DIMS*CNT_W-1:0] w_count_nxt;
  logic [NUM_DIMS-1:0]       w_at_max;
  logic                      w_busy;
  logic                      w_step_ok;
  logic                      w_carry;
  logic                      w_final;

  assign w_busy    = (r_state == ST_RUN);
  assign w_step_ok = i_step & w_busy;

  // Ripple carry from the innermost dim outward; a zero target behaves as a target of one.
  always_comb begin
    w_max       = '0;
    w_at_max    = '0;
    w_count_nxt = r_count;
    o_wrap      = '0;
    w_carry     = w_step_ok;
    for (int k = 0; k < NUM_DIMS; k++) begin
      w_max[k*CNT_W +: CNT_W] = (r_target[k*CNT_W +: CNT_W] == '0) ? '0 :
                                r_target[k*CNT_W +: CNT_W] - CNT_W'(1);
      w_at_max[k] = (r_count[k*CNT_W +: CNT_W] == w_max[k*CNT_W +: CNT_W]);
      if (w_carry) begin
        w_count_nxt[k*CNT_W +: CNT_W] = w_at_max[k] ? '0 :
                                        r_count[k*CNT_W +: CNT_W] + CNT_W'(1);
      end
      o_wrap[k] = w_carry & w_at_max[k];
      w_carry   = w_carry & w_at_max[k];
    end
    w_final = w_carry;
  end

  assign o_last  = w_busy & (&w_at_max);
  assign o_count = r_count;
  assign o_busy  = w_busy;
  assign o_done  = r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_target <= '0;
      r_count  <= '0;
      r_cont   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_clear) begin
        r_state <= ST_IDLE;
        r_count <= '0;
      end else if (i_start && (r_state == ST_IDLE)) begin
        r_state  <= ST_RUN;
        r_target <= i_target;
        r_cont   <= i_cont;
        r_count  <= '0;
      end else if (w_step_ok) begin
        r_count <= w_count_nxt;
        if (w_final) begin
          r_done <= 1'b1;
          if (!r_cont) begin
            r_state <= ST_IDLE;
          end
        end
      end
    end
  end

endmodule
